// File: rtl/read_clock_controller.sv
// Programmable read-clock generator: divides IN_50Mhz by 2*(div_reg+1), runs in bursts of
// rising edges or continuously, and stops cleanly so OUT_CLK never ends on a runt high phase.
module read_clock_controller #(
    parameter int unsigned COUNTER_WIDTH = 7,
    parameter int unsigned BURST_WIDTH   = 8
) (
    input  logic                     IN_50Mhz,
    input  logic                     IN_RESET_N,
    input  logic                     CFG_VALID,
    output logic                     CFG_READY,
    input  logic [COUNTER_WIDTH-1:0] CFG_DIV,
    input  logic                     START,
    input  logic                     STOP,
    input  logic [BURST_WIDTH-1:0]   BURST_LEN,
    output logic                     OUT_CLK,
    output logic                     OUT_RISE_EN,
    output logic                     OUT_FALL_EN,
    output logic                     BUSY,
    output logic                     DONE
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_t;

    state_t                   r_state,     w_state_nxt;
    logic [COUNTER_WIDTH-1:0] r_div,       w_div_nxt;
    logic [COUNTER_WIDTH-1:0] r_cnt,       w_cnt_nxt;
    logic [BURST_WIDTH-1:0]   r_edges,     w_edges_nxt;
    logic [BURST_WIDTH-1:0]   r_burst,     w_burst_nxt;
    logic                     r_out_clk,   w_out_clk_nxt;
    logic                     r_rise,      w_rise_nxt;
    logic                     r_fall,      w_fall_nxt;
    logic                     r_busy,      w_busy_nxt;
    logic                     r_done,      w_done_nxt;
    logic                     r_cfg_ready, w_cfg_ready_nxt;

    logic                     w_tc;
    logic                     w_burst_hit;

    assign w_tc        = (r_cnt == r_div);
    assign w_burst_hit = (r_burst != '0) && (r_edges == r_burst);

    always_ff @(posedge IN_50Mhz or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            r_state     <= StIdle;
            r_div       <= {COUNTER_WIDTH{1'b1}};
            r_cnt       <= '0;
            r_edges     <= '0;
            r_burst     <= '0;
            r_out_clk   <= 1'b0;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_div       <= w_div_nxt;
            r_cnt       <= w_cnt_nxt;
            r_edges     <= w_edges_nxt;
            r_burst     <= w_burst_nxt;
            r_out_clk   <= w_out_clk_nxt;
            r_rise      <= w_rise_nxt;
            r_fall      <= w_fall_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_cfg_ready <= w_cfg_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_div_nxt     = r_div;
        w_cnt_nxt     = r_cnt;
        w_edges_nxt   = r_edges;
        w_burst_nxt   = r_burst;
        w_out_clk_nxt = r_out_clk;
        w_rise_nxt    = 1'b0;
        w_fall_nxt    = 1'b0;
        w_done_nxt    = 1'b0;

        // CFG_READY is only ever high in IDLE, so the divider never changes mid-run.
        if (CFG_VALID && r_cfg_ready) begin
            w_div_nxt = CFG_DIV;
        end

        unique case (r_state)
            StIdle: begin
                if (START && !STOP) begin
                    w_cnt_nxt   = '0;
                    w_edges_nxt = '0;
                    w_burst_nxt = BURST_LEN;
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                if (STOP) begin
                    // Stop wins over a terminal count while low; a high phase is drained.
                    if (!r_out_clk) begin
                        w_cnt_nxt   = '0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = StIdle;
                    end else if (w_tc) begin
                        w_cnt_nxt     = '0;
                        w_out_clk_nxt = 1'b0;
                        w_fall_nxt    = 1'b1;
                        w_done_nxt    = 1'b1;
                        w_state_nxt   = StIdle;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                        w_state_nxt = StDrain;
                    end
                end else if (w_tc) begin
                    w_cnt_nxt     = '0;
                    w_out_clk_nxt = !r_out_clk;
                    if (!r_out_clk) begin
                        w_rise_nxt = 1'b1;
                        if (r_edges != {BURST_WIDTH{1'b1}}) begin
                            w_edges_nxt = r_edges + 1'b1;
                        end
                    end else begin
                        w_fall_nxt = 1'b1;
                        if (w_burst_hit) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = StIdle;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            StDrain: begin
                if (w_tc) begin
                    w_cnt_nxt     = '0;
                    w_out_clk_nxt = 1'b0;
                    w_fall_nxt    = 1'b1;
                    w_done_nxt    = 1'b1;
                    w_state_nxt   = StIdle;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_cnt_nxt     = '0;
                w_out_clk_nxt = 1'b0;
                w_state_nxt   = StIdle;
            end
        endcase

        w_busy_nxt      = (w_state_nxt != StIdle);
        w_cfg_ready_nxt = (w_state_nxt == StIdle);
    end

    assign CFG_READY   = r_cfg_ready;
    assign OUT_CLK     = r_out_clk;
    assign OUT_RISE_EN = r_rise;
    assign OUT_FALL_EN = r_fall;
    assign BUSY        = r_busy;
    assign DONE        = r_done;

endmodule
